// File: rtl/rob_param_if.sv
// rtl/rob_param_if.sv - Dispatch, writeback, operand lookup and commit bundle for rob_param
interface rob_param_if #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int NUM_WB = 2
);
  logic                     disp_valid_in;
  logic                     disp_ready_out;
  logic                     disp_is_store_in;
  logic [REG_W-1:0]         disp_rd_in;
  logic [ADDR_W-1:0]        disp_npc_in;
  logic [TAG_W-1:0]         disp_tag_out;
  logic [NUM_WB-1:0]        wb_valid_in;
  logic [NUM_WB*TAG_W-1:0]  wb_tag_in;
  logic [NUM_WB*DATA_W-1:0] wb_data_in;
  logic [NUM_WB-1:0]        wb_redir_in;
  logic [NUM_WB*ADDR_W-1:0] wb_npc_in;
  logic [TAG_W-1:0]         q1_tag_in;
  logic [TAG_W-1:0]         q2_tag_in;
  logic                     q1_valid_out;
  logic                     q2_valid_out;
  logic [DATA_W-1:0]        q1_data_out;
  logic [DATA_W-1:0]        q2_data_out;
  logic                     commit_valid_out;
  logic [REG_W-1:0]         commit_rd_out;
  logic [DATA_W-1:0]        commit_data_out;
  logic [TAG_W-1:0]         commit_tag_out;
  logic                     st_commit_out;
  logic                     flush_out;
  logic [ADDR_W-1:0]        redirect_pc_out;
  logic [TAG_W-1:0]         count_out;

  modport master (
    output disp_valid_in, disp_is_store_in, disp_rd_in, disp_npc_in,
    output wb_valid_in, wb_tag_in, wb_data_in, wb_redir_in, wb_npc_in,
    output q1_tag_in, q2_tag_in,
    input  disp_ready_out, disp_tag_out,
    input  q1_valid_out, q2_valid_out, q1_data_out, q2_data_out,
    input  commit_valid_out, commit_rd_out, commit_data_out, commit_tag_out,
    input  st_commit_out, flush_out, redirect_pc_out, count_out
  );

  modport slave (
    input  disp_valid_in, disp_is_store_in, disp_rd_in, disp_npc_in,
    input  wb_valid_in, wb_tag_in, wb_data_in, wb_redir_in, wb_npc_in,
    input  q1_tag_in, q2_tag_in,
    output disp_ready_out, disp_tag_out,
    output q1_valid_out, q2_valid_out, q1_data_out, q2_data_out,
    output commit_valid_out, commit_rd_out, commit_data_out, commit_tag_out,
    output st_commit_out, flush_out, redirect_pc_out, count_out
  );
endinterface

// File: rtl/rob_param.sv
// rtl/rob_param.sv - Parametrised reorder buffer: in-order commit, writeback bypass, mispredict flush
// Tags are index+1 so that tag 0 can mean "no dependency" to the reservation stations.
module rob_param #(
  parameter int DEPTH       = 16,
  parameter int TAG_W       = 5,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int REG_W       = 5,
  parameter int NUM_WB      = 2,
  parameter int FULL_MARGIN = 3
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rdy_in,
  rob_param_if.slave rob_bus
);
  localparam int IDX_W = TAG_W - 1;

  logic [DEPTH-1:0]  busy_q, done_q, store_q;
  logic [REG_W-1:0]  rd_q      [DEPTH];
  logic [ADDR_W-1:0] npc_q     [DEPTH];
  logic [ADDR_W-1:0] new_npc_q [DEPTH];
  logic [DATA_W-1:0] data_q    [DEPTH];
  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAG_W-1:0]  count_q, count_d;

  logic              commit_valid_q, st_commit_q, flush_q;
  logic [REG_W-1:0]  commit_rd_q;
  logic [DATA_W-1:0] commit_data_q;
  logic [TAG_W-1:0]  commit_tag_q;
  logic [ADDR_W-1:0] redirect_pc_q;

  logic              disp_ready, accept, head_ok, retire, mispredict;
  logic [NUM_WB-1:0] wb_hit;
  logic [IDX_W-1:0]  wb_idx [NUM_WB];

  assign disp_ready = !flush_q && ((int'(count_q) + FULL_MARGIN) < DEPTH);
  assign accept     = rdy_in && rob_bus.disp_valid_in && disp_ready;
  // Stores retire without waiting for done; the LSB performs them after commit.
  assign head_ok    = busy_q[head_q] && (store_q[head_q] || done_q[head_q]);
  assign retire     = rdy_in && head_ok;
  assign mispredict = retire && (new_npc_q[head_q] != npc_q[head_q]);

  assign head_d  = head_q + IDX_W'(retire);
  assign tail_d  = tail_q + IDX_W'(accept);
  assign count_d = count_q + TAG_W'(accept) - TAG_W'(retire);

  always_comb begin
    for (int p = 0; p < NUM_WB; p++) begin
      wb_idx[p] = IDX_W'(rob_bus.wb_tag_in[p*TAG_W +: TAG_W] - TAG_W'(1));
      wb_hit[p] = rob_bus.wb_valid_in[p] && (rob_bus.wb_tag_in[p*TAG_W +: TAG_W] != '0)
                  && busy_q[wb_idx[p]];
    end
  end

  for (genvar q = 0; q < 2; q++) begin : g_lookup
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic              valid;
    logic [DATA_W-1:0] data;

    assign tag = (q == 0) ? rob_bus.q1_tag_in : rob_bus.q2_tag_in;
    assign idx = IDX_W'(tag - TAG_W'(1));

    // Descending scan so the lowest-numbered writeback port wins on a duplicate tag.
    always_comb begin
      valid = done_q[idx];
      data  = data_q[idx];
      for (int p = NUM_WB - 1; p >= 0; p--) begin
        if (rob_bus.wb_valid_in[p] && (rob_bus.wb_tag_in[p*TAG_W +: TAG_W] == tag)) begin
          valid = 1'b1;
          data  = rob_bus.wb_data_in[p*DATA_W +: DATA_W];
        end
      end
      if (tag == '0) begin
        valid = 1'b1;
        data  = '0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q         <= '0;
      done_q         <= '0;
      store_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      st_commit_q    <= 1'b0;
      flush_q        <= 1'b0;
      commit_rd_q    <= '0;
      commit_data_q  <= '0;
      commit_tag_q   <= '0;
      redirect_pc_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]      <= '0;
        npc_q[i]     <= '0;
        new_npc_q[i] <= '0;
        data_q[i]    <= '0;
      end
    end else if (!rdy_in) begin
      commit_valid_q <= 1'b0;
      st_commit_q    <= 1'b0;
      flush_q        <= 1'b0;
    end else begin
      commit_valid_q <= 1'b0;
      st_commit_q    <= 1'b0;
      flush_q        <= 1'b0;
      if (retire) begin
        commit_valid_q <= !store_q[head_q] && (rd_q[head_q] != '0);
        commit_rd_q    <= rd_q[head_q];
        commit_data_q  <= data_q[head_q];
        commit_tag_q   <= TAG_W'(head_q) + TAG_W'(1);
        st_commit_q    <= store_q[head_q];
        busy_q[head_q] <= 1'b0;
      end
      if (mispredict) begin
        // The retiring entry's regfile write above still goes out; everything younger is squashed.
        flush_q       <= 1'b1;
        redirect_pc_q <= new_npc_q[head_q];
        busy_q        <= '0;
        head_q        <= '0;
        tail_q        <= '0;
        count_q       <= '0;
      end else begin
        for (int p = NUM_WB - 1; p >= 0; p--) begin
          if (wb_hit[p]) begin
            done_q[wb_idx[p]] <= 1'b1;
            data_q[wb_idx[p]] <= rob_bus.wb_data_in[p*DATA_W +: DATA_W];
            if (rob_bus.wb_redir_in[p]) begin
              new_npc_q[wb_idx[p]] <= rob_bus.wb_npc_in[p*ADDR_W +: ADDR_W];
            end
          end
        end
        if (accept) begin
          busy_q[tail_q]    <= 1'b1;
          done_q[tail_q]    <= 1'b0;
          store_q[tail_q]   <= rob_bus.disp_is_store_in;
          rd_q[tail_q]      <= rob_bus.disp_rd_in;
          npc_q[tail_q]     <= rob_bus.disp_npc_in;
          new_npc_q[tail_q] <= rob_bus.disp_npc_in;
        end
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
      end
    end
  end

  assign rob_bus.disp_ready_out   = disp_ready;
  assign rob_bus.disp_tag_out     = TAG_W'(tail_q) + TAG_W'(1);
  assign rob_bus.q1_valid_out     = g_lookup[0].valid;
  assign rob_bus.q1_data_out      = g_lookup[0].data;
  assign rob_bus.q2_valid_out     = g_lookup[1].valid;
  assign rob_bus.q2_data_out      = g_lookup[1].data;
  assign rob_bus.commit_valid_out = commit_valid_q;
  assign rob_bus.commit_rd_out    = commit_rd_q;
  assign rob_bus.commit_data_out  = commit_data_q;
  assign rob_bus.commit_tag_out   = commit_tag_q;
  assign rob_bus.st_commit_out    = st_commit_q;
  assign rob_bus.flush_out        = flush_q;
  assign rob_bus.redirect_pc_out  = redirect_pc_q;
  assign rob_bus.count_out        = count_q;
endmodule

// File: tb/tb_rob_param.sv
// tb/tb_rob_param.sv - Directed self-checking bench for rob_param
module tb_rob_param;
    logic clk;
    logic rst_n;
    logic rdy;
    int   total, passed, failed;

    rob_param_if #(.TAG_W(5), .DATA_W(32), .ADDR_W(32), .REG_W(5), .NUM_WB(2)) bus ();

    rob_param #(
        .DEPTH(16), .TAG_W(5), .DATA_W(32), .ADDR_W(32), .REG_W(5), .NUM_WB(2), .FULL_MARGIN(3)
    ) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .rdy_in  (rdy),
        .rob_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid_in    = 1'b0;
        bus.disp_is_store_in = 1'b0;
        bus.disp_rd_in       = '0;
        bus.disp_npc_in      = '0;
        bus.wb_valid_in      = '0;
        bus.wb_tag_in        = '0;
        bus.wb_data_in       = '0;
        bus.wb_redir_in      = '0;
        bus.wb_npc_in        = '0;
        bus.q1_tag_in        = '0;
        bus.q2_tag_in        = '0;
    endtask

    task automatic dispatch(input logic [4:0] rd, input logic [31:0] npc, input logic st);
        bus.disp_valid_in    = 1'b1;
        bus.disp_rd_in       = rd;
        bus.disp_npc_in      = npc;
        bus.disp_is_store_in = st;
        tick();
        bus.disp_valid_in    = 1'b0;
        bus.disp_is_store_in = 1'b0;
    endtask

    function automatic logic [31:0] wdata(input logic [4:0] t);
        return (t == 5'd16) ? 32'hDEAD : 32'h1000 + 32'(t);
    endfunction

    logic [4:0] cq [$];
    logic [4:0] exp_tag, prev_tag;
    int         ncommit;
    logic       saw_dead;

    initial begin
        total = 0; passed = 0; failed = 0;
        rst_n = 1'b0;
        rdy   = 1'b1;
        idle();
        #1;
        chk("reset_count", bus.count_out, 5'd0);
        chk("reset_disp_tag", bus.disp_tag_out, 5'd1);
        chk("reset_ready", bus.disp_ready_out, 1'b1);
        chk("reset_commit_valid", bus.commit_valid_out, 1'b0);
        chk("reset_flush", bus.flush_out, 1'b0);
        chk("reset_q0_valid", bus.q1_valid_out, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            chk("fill_ready", bus.disp_ready_out, 1'b1);
            chk("fill_disp_tag", bus.disp_tag_out, 5'(i + 1));
            dispatch(5'(i + 1), 32'h100 + 32'(i * 4), 1'b0);
        end
        chk("full_count", bus.count_out, 5'd13);
        chk("full_ready", bus.disp_ready_out, 1'b0);
        bus.disp_valid_in = 1'b1;
        tick();
        bus.disp_valid_in = 1'b0;
        chk("full_drop_count", bus.count_out, 5'd13);
        chk("full_drop_tag", bus.disp_tag_out, 5'd14);

        bus.wb_valid_in = 2'b01;
        bus.wb_tag_in   = {5'd0, 5'd1};
        bus.wb_data_in  = {32'd0, 32'h11};
        bus.q1_tag_in   = 5'd1;
        bus.q2_tag_in   = 5'd2;
        #1;
        chk("byp_head_valid", bus.q1_valid_out, 1'b1);
        chk("byp_head_data", bus.q1_data_out, 32'h11);
        chk("pending_q2_valid", bus.q2_valid_out, 1'b0);
        tick();
        idle();
        chk("wb_same_cycle_no_commit", bus.commit_valid_out, 1'b0);
        chk("wb_count", bus.count_out, 5'd13);
        tick();
        chk("retire_valid", bus.commit_valid_out, 1'b1);
        chk("retire_rd", bus.commit_rd_out, 5'd1);
        chk("retire_data", bus.commit_data_out, 32'h11);
        chk("retire_tag", bus.commit_tag_out, 5'd1);
        chk("retire_count", bus.count_out, 5'd12);
        chk("retire_ready", bus.disp_ready_out, 1'b1);

        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", bus.count_out, 5'd0);
        chk("async_rst_tag", bus.disp_tag_out, 5'd1);
        chk("async_rst_commit", bus.commit_valid_out, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        dispatch(5'd1, 32'h200, 1'b0);
        dispatch(5'd2, 32'h204, 1'b0);
        dispatch(5'd3, 32'h208, 1'b0);
        bus.wb_valid_in = 2'b10;
        bus.wb_tag_in   = {5'd3, 5'd0};
        bus.wb_data_in  = {32'h55, 32'h0};
        bus.q1_tag_in   = 5'd3;
        #1;
        chk("bypass_valid", bus.q1_valid_out, 1'b1);
        chk("bypass_data", bus.q1_data_out, 32'h55);
        bus.wb_valid_in = 2'b11;
        bus.wb_tag_in   = {5'd3, 5'd3};
        bus.wb_data_in  = {32'h55, 32'h66};
        #1;
        chk("bypass_dup_port0_wins", bus.q1_data_out, 32'h66);
        tick();
        idle();
        bus.q1_tag_in = 5'd3;
        #1;
        chk("stored_valid", bus.q1_valid_out, 1'b1);
        chk("stored_dup_data", bus.q1_data_out, 32'h66);
        chk("head_not_done", bus.commit_valid_out, 1'b0);
        bus.wb_valid_in = 2'b11;
        bus.wb_tag_in   = {5'd2, 5'd1};
        bus.wb_data_in  = {32'hA2, 32'hA1};
        tick();
        idle();
        tick();
        chk("order1_tag", bus.commit_tag_out, 5'd1);
        chk("order1_data", bus.commit_data_out, 32'hA1);
        tick();
        chk("order2_tag", bus.commit_tag_out, 5'd2);
        chk("order2_data", bus.commit_data_out, 32'hA2);
        tick();
        chk("order3_tag", bus.commit_tag_out, 5'd3);
        chk("order3_rd", bus.commit_rd_out, 5'd3);
        chk("order3_data", bus.commit_data_out, 32'h66);
        chk("order_count", bus.count_out, 5'd0);

        dispatch(5'd0, 32'h300, 1'b1);
        chk("store_count", bus.count_out, 5'd1);
        chk("store_not_yet", bus.st_commit_out, 1'b0);
        tick();
        chk("store_commit", bus.st_commit_out, 1'b1);
        chk("store_no_regwrite", bus.commit_valid_out, 1'b0);
        chk("store_count_dec", bus.count_out, 5'd0);
        dispatch(5'd0, 32'h304, 1'b0);
        chk("store_pulse_end", bus.st_commit_out, 1'b0);
        bus.wb_valid_in = 2'b01;
        bus.wb_tag_in   = {5'd0, 5'd5};
        tick();
        idle();
        tick();
        chk("rd0_no_regwrite", bus.commit_valid_out, 1'b0);
        chk("rd0_tag", bus.commit_tag_out, 5'd5);
        chk("rd0_count", bus.count_out, 5'd0);

        exp_tag  = 5'd6;
        prev_tag = 5'd0;
        ncommit  = 0;
        saw_dead = 1'b0;
        for (int i = 0; i < 42; i++) begin
            bus.disp_valid_in = (i < 40);
            bus.disp_rd_in    = 5'd7;
            bus.disp_npc_in   = 32'h1000 + 32'(i * 4);
            if (i < 40) begin
                chk("wrap_disp_tag", bus.disp_tag_out, exp_tag);
                cq.push_back(exp_tag);
            end
            bus.wb_valid_in = {1'b0, prev_tag != 5'd0};
            bus.wb_tag_in   = {5'd0, prev_tag};
            bus.wb_data_in  = {32'd0, wdata(prev_tag)};
            tick();
            if (i < 40) begin
                prev_tag = exp_tag;
                exp_tag  = (exp_tag == 5'd16) ? 5'd1 : exp_tag + 5'd1;
            end else begin
                prev_tag = 5'd0;
            end
            if (bus.commit_valid_out) begin
                chk("wrap_commit_expected", cq.size() != 0, 1'b1);
                if (cq.size() != 0) begin
                    chk("wrap_commit_tag", bus.commit_tag_out, cq[0]);
                    chk("wrap_commit_data", bus.commit_data_out, wdata(cq[0]));
                    chk("wrap_commit_rd", bus.commit_rd_out, 5'd7);
                    if (cq[0] == 5'd16 && bus.commit_data_out === 32'hDEAD) saw_dead = 1'b1;
                    void'(cq.pop_front());
                    ncommit++;
                end
            end
        end
        idle();
        chk("wrap_commit_total", ncommit, 40);
        chk("wrap_tag16_dead", saw_dead, 1'b1);
        chk("wrap_count", bus.count_out, 5'd0);

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        dispatch(5'd3, 32'h100, 1'b0);
        dispatch(5'd4, 32'h104, 1'b0);
        dispatch(5'd5, 32'h108, 1'b0);
        bus.wb_valid_in = 2'b11;
        bus.wb_tag_in   = {5'd2, 5'd1};
        bus.wb_data_in  = {32'h22, 32'h1};
        bus.wb_redir_in = 2'b10;
        bus.wb_npc_in   = {32'h200, 32'h0};
        tick();
        idle();
        chk("mp_pre_commit", bus.commit_valid_out, 1'b0);
        tick();
        chk("mp_first_tag", bus.commit_tag_out, 5'd1);
        chk("mp_first_no_flush", bus.flush_out, 1'b0);
        bus.disp_valid_in = 1'b1;
        bus.disp_rd_in    = 5'd9;
        bus.wb_valid_in   = 2'b01;
        bus.wb_tag_in     = {5'd0, 5'd3};
        bus.wb_data_in    = {32'd0, 32'h33};
        tick();
        chk("mp_flush", bus.flush_out, 1'b1);
        chk("mp_redirect", bus.redirect_pc_out, 32'h200);
        chk("mp_count", bus.count_out, 5'd0);
        chk("mp_regwrite", bus.commit_valid_out, 1'b1);
        chk("mp_rd", bus.commit_rd_out, 5'd4);
        chk("mp_data", bus.commit_data_out, 32'h22);
        chk("mp_tag", bus.commit_tag_out, 5'd2);
        chk("mp_ready_low", bus.disp_ready_out, 1'b0);
        chk("mp_disp_tag", bus.disp_tag_out, 5'd1);
        bus.wb_valid_in = '0;
        tick();
        chk("mp_flush_end", bus.flush_out, 1'b0);
        chk("mp_still_empty", bus.count_out, 5'd0);
        chk("mp_ready_back", bus.disp_ready_out, 1'b1);
        chk("mp_commit_end", bus.commit_valid_out, 1'b0);
        idle();

        rdy = 1'b0;
        bus.disp_valid_in = 1'b1;
        tick();
        chk("stall_count", bus.count_out, 5'd0);
        chk("stall_tag", bus.disp_tag_out, 5'd1);
        rdy = 1'b1;
        idle();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
